// File: rtl/wb_req_bridge.sv
// Wishbone classic slave to request/write/read fabric bridge, one access in flight.
// Latency: zero-wait target acks a write at n+3 and a read at n+3 (read beat at n+2).
// Backpressure: the request is held until req_ready; read waits for read_valid; no write backpressure.
module wb_req_bridge (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [29:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [2:0]  req_len,
    output logic [3:0]  req_mask,
    output logic [31:0] req_addr,
    output logic        write_valid,
    output logic [31:0] write_data,
    input  logic        read_valid,
    input  logic [31:0] read_data,
    output logic        read_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RDATA,
        S_ACK
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_abort;
    logic [29:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [31:0] r_dat_o;
    logic        w_start;
    logic        w_busy;

    assign w_start = (r_state == S_IDLE) && cyc_i && stb_i;
    assign w_busy  = (r_state == S_REQ) || (r_state == S_WDATA) || (r_state == S_RDATA);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_valid   = 1'b0;
        write_valid = 1'b0;
        read_ack    = 1'b0;
        ack_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    w_next = r_we ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                write_valid = 1'b1;
                w_next      = S_ACK;
            end
            S_RDATA: begin
                read_ack = read_valid;
                if (read_valid) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                ack_o  = !r_abort;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // An abandoned cycle still drains the fabric side; only the Wishbone ack is suppressed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            r_adr   <= 30'd0;
            r_sel   <= 4'd0;
            r_dat   <= 32'd0;
            r_dat_o <= 32'd0;
        end else begin
            if (w_start) begin
                r_we    <= we_i;
                r_adr   <= adr_i;
                r_sel   <= sel_i;
                r_dat   <= dat_i;
                r_abort <= 1'b0;
            end else if (w_busy && !cyc_i) begin
                r_abort <= 1'b1;
            end
            if ((r_state == S_RDATA) && read_valid) begin
                r_dat_o <= read_data;
            end
        end
    end

    assign req_we     = r_we;
    assign req_len    = 3'd0;
    assign req_mask   = r_sel;
    assign req_addr   = {r_adr, 2'b00};
    assign write_data = r_dat;
    assign dat_o      = r_dat_o;

endmodule

// File: tb/tb_wb_req_bridge.sv
// Directed bench for wb_req_bridge with request/write/ack scoreboards and cycle-exact timing checks.
module tb_wb_req_bridge;

    logic        clk_i;
    logic        rst_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [29:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic        write_valid;
    logic [31:0] write_data;
    logic        read_valid;
    logic [31:0] read_data;
    logic        read_ack;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_ack_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          n_req = 0;
    int          n_acks = 0;
    logic [31:0] model_dat;

    wb_req_bridge dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .adr_i       (adr_i),
        .sel_i       (sel_i),
        .dat_i       (dat_i),
        .ack_o       (ack_o),
        .dat_o       (dat_o),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_len     (req_len),
        .req_mask    (req_mask),
        .req_addr    (req_addr),
        .write_valid (write_valid),
        .write_data  (write_data),
        .read_valid  (read_valid),
        .read_data   (read_data),
        .read_ack    (read_ack)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int sz);
        checks++;
        assert (sz != 0) else begin
            errors++;
            $error("FAIL %s observed=unexpected_output expected=none", tag);
        end
    endtask

    // Scoreboard monitor: request fields at acceptance, hold stability, write beats, ack data.
    initial begin
        req_t        r;
        logic [31:0] w;
        bit          hold;
        logic [31:0] h_addr;
        logic [3:0]  h_mask;
        hold = 0;
        h_addr = '0;
        h_mask = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (req_valid) begin
                    if (hold) begin
                        chk("req_hold_addr", req_addr, h_addr);
                        chk("req_hold_mask", 32'(req_mask), 32'(h_mask));
                    end
                    if (req_ready) begin
                        n_req++;
                        chk_nonempty("req_unexpected", exp_req.size());
                        if (exp_req.size() != 0) begin
                            r = exp_req.pop_front();
                            chk("req_we", 32'(req_we), 32'(r.we));
                            chk("req_addr", req_addr, r.addr);
                            chk("req_mask", 32'(req_mask), 32'(r.mask));
                            chk("req_len", 32'(req_len), 32'd0);
                        end
                    end
                    hold = !req_ready;
                    h_addr = req_addr;
                    h_mask = req_mask;
                end else begin
                    hold = 0;
                end
                if (write_valid) begin
                    chk_nonempty("write_unexpected", exp_wd.size());
                    if (exp_wd.size() != 0) begin
                        w = exp_wd.pop_front();
                        chk("write_data", write_data, w);
                    end
                end
                if (ack_o) begin
                    n_acks++;
                    chk_nonempty("ack_unexpected", exp_ack_q.size());
                    if (exp_ack_q.size() != 0) begin
                        w = exp_ack_q.pop_front();
                        chk("dat_o_at_ack", dat_o, w);
                    end
                end
            end else begin
                hold = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the access.
    task automatic access(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rdata, input int abort_at, input bit keep,
                          output int ack_e);
        int   n, e, exp_ack, req_e, rv_e, n_rv, n_wv, n_ra, n_ack;
        bit   seen;
        req_t r;
        n       = cyc_cnt + 1;
        req_e   = n + 1 + rdy_dly;
        rv_e    = req_e + 1 + rv_dly;
        exp_ack = we ? req_e + 2 : rv_e + 1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        req_ready = 1'b0; read_valid = 1'b0;
        r.we = we; r.addr = {adr, 2'b00}; r.mask = sel;
        exp_req.push_back(r);
        if (we) exp_wd.push_back(dat);
        else model_dat = rdata;
        if (abort_at == 0) exp_ack_q.push_back(model_dat);
        n_rv = 0; n_wv = 0; n_ra = 0; n_ack = 0; ack_e = -1; seen = 0;
        @(posedge clk_i); #1;
        e = n + 1;
        while (!seen && (e <= exp_ack + 4) && !((abort_at != 0) && (e > exp_ack))) begin
            req_ready  = (e == req_e);
            read_valid = !we && (e == rv_e);
            read_data  = read_valid ? rdata : (32'hBAD0_0000 ^ 32'(e));
            if ((abort_at != 0) && (e >= n + abort_at)) begin
                cyc_i = 1'b0;
                stb_i = 1'b0;
            end
            @(negedge clk_i);
            if (req_valid) n_rv++;
            if (write_valid) begin
                n_wv++;
                chk("write_valid_cycle", 32'(e), 32'(n + 2 + rdy_dly));
            end
            if (read_ack) n_ra++;
            if (ack_o) begin
                n_ack++;
                ack_e = e;
                seen = 1;
            end
            @(posedge clk_i); #1;
            e++;
        end
        req_ready = 1'b0;
        read_valid = 1'b0;
        if (!keep || (abort_at != 0)) begin
            cyc_i = 1'b0;
            stb_i = 1'b0;
        end
        chk("req_valid_cycles", 32'(n_rv), 32'(rdy_dly + 1));
        chk("write_beats", 32'(n_wv), 32'(we));
        chk("read_acks", 32'(n_ra), 32'(!we));
        if (abort_at == 0) begin
            chk("ack_count", 32'(n_ack), 32'd1);
            chk("ack_cycle", 32'(ack_e), 32'(exp_ack));
        end else begin
            chk("ack_count_abort", 32'(n_ack), 32'd0);
        end
        chk("dat_o_hold", dat_o, model_dat);
    endtask

    initial begin
        int   ae, ae1, ae2, ae3, n0, a0;
        req_t r;
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; sel_i = '0;
        dat_i = '0; req_ready = 1'b0; read_valid = 1'b1; read_data = 32'hFFFF_FFFF;
        model_dat = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ctrl", {20'd0, ack_o, req_valid, req_we, write_valid, read_ack, req_len, req_mask}, 32'd0);
        chk("reset_req_addr", req_addr, 32'd0);
        chk("reset_dat_o", dat_o, 32'd0);
        chk("reset_write_data", write_data, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // read_valid while idle must be ignored
        read_valid = 1'b1; read_data = 32'hFFFF_0000;
        @(negedge clk_i);
        chk("early_read_ack", 32'(read_ack), 32'd0);
        @(posedge clk_i); #1;
        read_valid = 1'b0;

        access(1'b1, 30'h0000_0100, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 1'b0, ae);
        access(1'b0, 30'h0000_0010, 4'hF, 32'h0, 5, 3, 32'h1234_5678, 0, 1'b0, ae);
        access(1'b1, 30'h3FF0_0001, 4'b0100, 32'hA5C3_0F96, 0, 0, 32'h0, 0, 1'b0, ae);
        access(1'b1, 30'h0000_0055, 4'h0, 32'h1111_2222, 1, 0, 32'h0, 0, 1'b0, ae);

        // abort in REQ during a read, then a normal read
        access(1'b0, 30'h0000_0020, 4'hF, 32'h0, 2, 1, 32'hCAFE_F00D, 1, 1'b0, ae);
        access(1'b0, 30'h0000_0021, 4'h3, 32'h0, 0, 0, 32'h0BAD_C0DE, 0, 1'b0, ae);
        // abort in WDATA
        access(1'b1, 30'h0000_0022, 4'hF, 32'h5A5A_5A5A, 0, 0, 32'h0, 2, 1'b0, ae);

        // reset while waiting for the read beat
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 30'h0000_002A; sel_i = 4'hF; req_ready = 1'b1;
        r.we = 1'b0; r.addr = {30'h0000_002A, 2'b00}; r.mask = 4'hF;
        exp_req.push_back(r);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        req_ready = 1'b0;
        read_valid = 1'b1; read_data = 32'h7777_8888;
        #1;
        chk("rdata_read_ack", 32'(read_ack), 32'd1);
        chk("dat_o_before_reset", dat_o, model_dat);
        rst_i = 1'b0;
        #1;
        chk("midreset_ctrl", {20'd0, ack_o, req_valid, req_we, write_valid, read_ack, req_len, req_mask}, 32'd0);
        chk("midreset_req_addr", req_addr, 32'd0);
        chk("midreset_dat_o", dat_o, 32'd0);
        model_dat = 32'd0;
        cyc_i = 1'b0; stb_i = 1'b0; read_valid = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        access(1'b1, 30'h0000_0333, 4'hF, 32'h600D_F00D, 0, 0, 32'h0, 0, 1'b0, ae);

        // back-to-back with strobe held
        n0 = n_req;
        a0 = n_acks;
        access(1'b1, 30'h0000_0200, 4'hF, 32'h0000_0001, 0, 0, 32'h0, 0, 1'b1, ae1);
        access(1'b0, 30'h0000_0201, 4'hF, 32'h0, 0, 0, 32'h2222_0002, 0, 1'b1, ae2);
        access(1'b1, 30'h0000_0202, 4'h8, 32'h0000_0003, 0, 0, 32'h0, 0, 1'b0, ae3);
        repeat (4) @(posedge clk_i);
        #1;
        chk("b2b_spacing_1", 32'(ae2 - ae1), 32'd4);
        chk("b2b_spacing_2", 32'(ae3 - ae2), 32'd4);
        chk("b2b_requests", 32'(n_req - n0), 32'd3);
        chk("b2b_acks", 32'(n_acks - a0), 32'd3);

        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("wd_queue_drained", 32'(exp_wd.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_req_bridge.md
# wb_req_bridge

Wishbone classic slave that converts single-beat bus cycles into transactions on the internal request/write/read interface used by `req_sdram` and `cpuif`. It is the reverse of `req_wb_bridge`: it lets a Wishbone master reach the request fabric. Typical masters are a DMA engine or a VGA framebuffer fetcher reaching SDRAM through `req_mux`. It issues one single-beat request per Wishbone cycle and has no posting or buffering beyond one access.

## Interface
Parameters: none.

Ports:
- `clk_i` in 1: system clock (`sys_clk`).
- `rst_i` in 1: reset, asynchronous, active-low.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe.
- `we_i` in 1: write enable.
- `adr_i` in 30: word address.
- `sel_i` in 4: byte selects; bit 3 is `dat[31:24]`.
- `dat_i` in 32: write data.
- `ack_o` out 1: one-cycle acknowledge.
- `dat_o` out 32: read data, valid with `ack_o`.
- `req_valid` out 1: request valid.
- `req_ready` in 1: request accepted by target.
- `req_we` out 1: 1 = write.
- `req_len` out 3: beats minus one; always 3'd0.
- `req_mask` out 4: byte enables, equal to latched `sel_i`.
- `req_addr` out 32: byte address, `{adr_i, 2'b00}`.
- `write_valid` out 1: write beat strobe.
- `write_data` out 32: write beat data.
- `read_valid` in 1: read beat available.
- `read_data` in 32: read beat data.
- `read_ack` out 1: read beat consumed.

## Operation
FSM states: IDLE, REQ, WDATA, RDATA, ACK.

- **IDLE**
  - When `cyc_i & stb_i` is high, latch `we_i`, `adr_i`, `sel_i` and `dat_i`, clear the abort flag, and go to REQ.
- **REQ**
  - `req_valid`=1. Request fields come from the latched values and stay stable until accepted.
  - When `req_ready` is 1, the request is accepted that cycle. Go to WDATA if it is a write, RDATA if it is a read.
- **WDATA**
  - `write_valid`=1 for exactly one cycle, with `write_data` = latched data.
  - Go to ACK. The target must consume the beat; there is no write backpressure.
- **RDATA**
  - Wait for `read_valid`.
  - In the cycle it is 1: `read_ack`=1 for that one cycle, capture `read_data` into `dat_o`, and go to ACK.
- **ACK**
  - `ack_o`=1 for one cycle unless aborted.
  - Go to IDLE. A strobe still high in IDLE on the next cycle is treated as a new access.

Abort rule:
- If `cyc_i` falls in REQ, WDATA or RDATA, set the abort flag.
- The request-side transaction always completes, because `req_valid` may not drop before `req_ready` and read beats must be drained.
- With the abort flag set, ACK produces `ack_o`=0 and `dat_o` is still updated.

Other rules:
- `req_len` is tied to 0 and `req_addr[1:0]` to 0.
- `sel_i`=0 passes through as `req_mask`=0: the request is issued and acked normally.
- `dat_o` holds its last value outside ACK.

## Timing
- **Reset:** asynchronous, active-low. While `rst_i`=0, the state is IDLE and every output is 0, including `dat_o`, the abort flag and the latched fields. Asserting reset mid-transaction drops the transaction immediately. The request-side target must share the reset.
- **Cycle numbering:** n = the edge that samples `cyc_i & stb_i` in IDLE.
- **Request:** `req_valid` rises at n+1 and is held until the first edge with `req_ready`=1.
- **Write, zero-wait target:** `req_ready`=1 at n+1, `write_valid` at n+2, `ack_o` at n+3.
- **Read, zero-wait target:** `read_valid`=1 at n+2 gives `read_ack` at n+2 and `ack_o` plus `dat_o` at n+3.
- **Throughput:** back-to-back accesses take at least 4 cycles each.
- **Combinational path:** `read_ack` depends on `read_valid` in RDATA only. There are no other combinational input-to-output paths.
- **Early `read_valid`:** a `read_valid` asserted while not in RDATA is ignored and gets no ack.
- **Simultaneous `req_ready` and `cyc_i` fall in REQ:** the request is accepted and the abort flag is set.

## Test plan
- **Single write:** write `adr_i`=30'h0000_0100, `sel_i`=4'hF, `dat_i`=32'hDEADBEEF with a zero-wait target. Expect `req_addr`=32'h0000_0400, `req_we`=1, `req_mask`=4'hF, `req_len`=0, `write_data`=32'hDEADBEEF for exactly one cycle at n+2, and `ack_o` at n+3.
- **Read with slow target:** read `adr_i`=30'h10, with `req_ready` delayed 5 cycles and `read_valid` (`read_data`=32'h12345678) delayed 3 more. Expect `req_valid` held stable for all 5 wait cycles, a single `read_ack`, then `ack_o` with `dat_o`=32'h12345678 one cycle later.
- **Byte lane:** write with `sel_i`=4'b0100. Expect `req_mask`=4'b0100 and data passed unchanged.
- **Abort:** drop `cyc_i` in REQ during a read. Expect the request still completes, `read_ack` is issued once, `ack_o` stays 0, and the next access behaves normally.
- **Reset mid-operation:** assert `rst_i` low in RDATA. Expect all outputs to be 0 immediately. After release, a new write completes with the n+3 ack.
- **Back-to-back:** hold `stb_i` high for 3 accesses with a zero-wait target. Expect exactly 3 requests, 3 acks, and a 4-cycle spacing between acks.
